cdec8_ctrl: RTL and testbench
=============================

// Module: cdec8_ctrl
// PURPOSE
//  CDEC8 control unit (sequencer): drives the datapath 17-bit control word from its fetch/execute FSM.
//  Consumes the datapath's instruction register I and flags SZCy.
//  Exports state and halted to the PC debug monitor (resad 0x0B = state).
//  Moore machine; one state per clock cycle.
// PARAMETERS
//  none (all encodings live in my_const.vh)
// PORTS
//  clock    in   1  system clock; all state changes on posedge
//  reset_N  in   1  asynchronous, active-low reset
//  run      in   1  panel run enable; sampled only at instruction boundaries
//  I        in   8  instruction register from datapath
//  SZCy     in   3  {S,Z,Cy} flag register from datapath
//  ctrl     out  17 {mmrw[1:0],fwr,rwr,xdst[3:0],aluop[4:0],xsrc[3:0]}
//  state    out  8  {4'h0,st[3:0]} for debug monitor
//  halted   out  1  1 while in S_HALT
// BEHAVIOUR
//  Codes:
//   - xsrc: PC0 A1 B2 C3 R4 RDR5 FLG6 FF7 IPORT8.
//   - xdst: PC0 A1 B2 C3 MAR4 WDR5 T6 I7 OPORT8 NONE=F.
//   - mmrw: 00 idle, 10 read, 01 write.
//  IDLE word: mmrw=00, fwr=0, rwr=0, xdst=F, aluop=ALU_THRU, xsrc=7.
//   - Output in S_IDLE and S_HALT, and for every field not listed below.
//  Reset (async): st=S_IDLE, ctrl=IDLE word, halted=0. A reset mid-instruction abandons it.
//  S_IDLE -> S_F0 when run=1, else stay.
//  Fetch states:
//   - S_F0: PC->MAR.
//   - S_F1: mmrw=10; xsrc=PC, aluop=ALU_INC, rwr=1.
//   - S_F2: R->PC.
//   - S_F3: RDR->I; next state decoded from I (I latches on the falling edge inside F3).
//  Operand states (two-byte instructions):
//   - S_O0/O1/O2 are identical to F0/F1/F2.
//   - From S_O2, go to S_E0, except Jcc with a false condition, which goes to the boundary.
//  Boundary: after the last state of an instruction -> S_F0 if run=1, else S_IDLE.
//  Register field r: 00 A, 01 B, 10 C, 11 special.
//   - r=11 as source: xsrc=7 (0xFF).
//   - r=11 as destination: xdst=F.
//  ISA by I[7:4]; I[1:0]=r/rs, I[3:2]=rd:
//   - 0 NOP: F3 -> boundary.
//   - 1 LD r,#imm: O*, E0 RDR->r.
//   - 2 LD r,[a]: O*, E0 RDR->MAR, E1 mmrw=10, E2 RDR->r.
//   - 3 ST r,[a]: O*, E0 RDR->MAR, E1 r->WDR, E2 mmrw=01.
//   - 4 MOV rd,rs: E0 rs->rd.
//   - 5/6/7/8 ADD/SUB/AND/OR A,rs:
//       E0 rs->T;
//       E1 xsrc=A, aluop=ALU_ADD/SUB/AND/OR, rwr=1, fwr=1;
//       E2 R->A.
//   - 9 INC/DEC r (I[2]=0 INC, 1 DEC):
//       E0 xsrc=r, aluop=ALU_INC/DEC, rwr=1, fwr=1;
//       E1 R->r.
//   - A JMP a: O*, E0 RDR->PC.
//   - B Jcc a: condition I[1:0] = 00 Z, 01 Cy, 10 S, 11 !Z.
//       Condition is SZCy sampled in S_O2. True: E0 RDR->PC. False: operand skipped, no PC write.
//   - C IN r: E0 IPORT->r.
//   - D OUT r: E0 r->OPORT.
//   - F HLT: F3 -> S_HALT. Only reset exits S_HALT; run is ignored there.
//   - E: undefined, executes as NOP.
//  Flags are only written in ALU/INC/DEC execute states. Never read and write flags in the same state.
// STRUCTURE
//  my_const.vh holds:
//   - XSRC_*, XDST_* (incl. XDST_NONE), MM_IDLE/RD/WR, ALU_* opcodes;
//   - st codes S_IDLE,S_F0..S_F3,S_O0..S_O2,S_E0..S_E2,S_HALT;
//   - CTRL_IDLE.
//  Sub-module cdec8_ctrl_dec: combinational (st,I,SZCy) -> {ctrl,next_st}.
//  Top holds only the st register and output wiring.
// TESTING
//  1. Reset, run=0 -> st stays S_IDLE, ctrl=CTRL_IDLE, halted=0.
//     run=1 -> next cycle S_F0 with xsrc=0000, xdst=0100.
//  2. I=0x10, run=1 -> F0,F1,F2,F3,O0,O1,O2,E0 (xsrc=0101, xdst=0001) -> F0.
//     F1 shows mmrw=10, rwr=1, aluop=ALU_INC.
//  3. I=0xB0 (JZ):
//     - SZCy=010 -> E0 xsrc=0101, xdst=0000.
//     - SZCy=000 -> O2 -> F0 with no PC write after O2.
//  4. I=0x52 (ADD A,C):
//     E0 xsrc=0011 xdst=0110; E1 xsrc=0001 aluop=ALU_ADD rwr=1 fwr=1; E2 xsrc=0100 xdst=0001.
//  5. I=0x3B (ST C,[a]): E1 xsrc=0011 xdst=0101; E2 mmrw=01.
//     Drop run during E1 -> completes E2 then S_IDLE.
//  6. I=0xF0 -> S_HALT, halted=1 held 20 cycles with run=1.
//     reset_N low mid-E1 of 0x52 -> st=S_IDLE immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cdec8_ctrl_pkg.sv
// CDEC8 sequencer constants: state codes, control-word field encodings,
// ISA opcodes, the packed control word layout and small decode helpers.
package cdec8_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'h0,
    S_F0   = 4'h1,
    S_F1   = 4'h2,
    S_F2   = 4'h3,
    S_F3   = 4'h4,
    S_O0   = 4'h5,
    S_O1   = 4'h6,
    S_O2   = 4'h7,
    S_E0   = 4'h8,
    S_E1   = 4'h9,
    S_E2   = 4'hA,
    S_HALT = 4'hB
  } st_e;

  typedef enum logic [3:0] {
    XSRC_PC    = 4'h0,
    XSRC_A     = 4'h1,
    XSRC_B     = 4'h2,
    XSRC_C     = 4'h3,
    XSRC_R     = 4'h4,
    XSRC_RDR   = 4'h5,
    XSRC_FLG   = 4'h6,
    XSRC_FF    = 4'h7,
    XSRC_IPORT = 4'h8
  } xsrc_e;

  typedef enum logic [3:0] {
    XDST_PC    = 4'h0,
    XDST_A     = 4'h1,
    XDST_B     = 4'h2,
    XDST_C     = 4'h3,
    XDST_MAR   = 4'h4,
    XDST_WDR   = 4'h5,
    XDST_T     = 4'h6,
    XDST_I     = 4'h7,
    XDST_OPORT = 4'h8,
    XDST_NONE  = 4'hF
  } xdst_e;

  typedef enum logic [1:0] {
    MM_IDLE = 2'b00,
    MM_RD   = 2'b10,
    MM_WR   = 2'b01
  } mm_e;

  typedef enum logic [4:0] {
    ALU_THRU = 5'd0,
    ALU_ADD  = 5'd1,
    ALU_SUB  = 5'd2,
    ALU_AND  = 5'd3,
    ALU_OR   = 5'd4,
    ALU_INC  = 5'd5,
    ALU_DEC  = 5'd6
  } alu_e;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LDM = 4'h2;
  localparam logic [3:0] OP_ST  = 4'h3;
  localparam logic [3:0] OP_MOV = 4'h4;
  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_AND = 4'h7;
  localparam logic [3:0] OP_OR  = 4'h8;
  localparam logic [3:0] OP_INC = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_JCC = 4'hB;
  localparam logic [3:0] OP_IN  = 4'hC;
  localparam logic [3:0] OP_OUT = 4'hD;
  localparam logic [3:0] OP_UND = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // 17-bit datapath control word, MSB first.
  typedef struct packed {
    mm_e   mm;
    logic  fwr;
    logic  rwr;
    xdst_e xdst;
    alu_e  aluop;
    xsrc_e xsrc;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{mm: MM_IDLE, fwr: 1'b0, rwr: 1'b0,
                                  xdst: XDST_NONE, aluop: ALU_THRU,
                                  xsrc: XSRC_FF};

  // Register field as a bus source; 11 sources the 0xFF constant.
  function automatic xsrc_e reg_src(input logic [1:0] r);
    case (r)
      2'b00:   reg_src = XSRC_A;
      2'b01:   reg_src = XSRC_B;
      2'b10:   reg_src = XSRC_C;
      default: reg_src = XSRC_FF;
    endcase
  endfunction

  // Register field as a bus destination; 11 discards the value.
  function automatic xdst_e reg_dst(input logic [1:0] r);
    case (r)
      2'b00:   reg_dst = XDST_A;
      2'b01:   reg_dst = XDST_B;
      2'b10:   reg_dst = XDST_C;
      default: reg_dst = XDST_NONE;
    endcase
  endfunction

  // szcy = {S,Z,Cy}; cc: 00 Z, 01 Cy, 10 S, 11 !Z.
  function automatic logic jcc_taken(input logic [1:0] cc, input logic [2:0] szcy);
    case (cc)
      2'b00:   jcc_taken = szcy[1];
      2'b01:   jcc_taken = szcy[0];
      2'b10:   jcc_taken = szcy[2];
      default: jcc_taken = ~szcy[1];
    endcase
  endfunction

  function automatic alu_e alu_of(input logic [3:0] op);
    case (op)
      OP_SUB:  alu_of = ALU_SUB;
      OP_AND:  alu_of = ALU_AND;
      OP_OR:   alu_of = ALU_OR;
      default: alu_of = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/cdec8_ctrl_if.sv
// Sequencer <-> datapath/panel bundle.
//   run    : panel run enable
//   I      : instruction register from datapath
//   SZCy   : {S,Z,Cy} flags from datapath
//   ctrl   : 17-bit datapath control word
//   state  : {4'h0, st} for the debug monitor
//   halted : high while halted
interface cdec8_ctrl_if;
  logic        run;
  logic [7:0]  I;
  logic [2:0]  SZCy;
  logic [16:0] ctrl;
  logic [7:0]  state;
  logic        halted;

  modport master (output run, output I, output SZCy,
                  input  ctrl, input state, input halted);
  modport slave  (input  run, input I, input SZCy,
                  output ctrl, output state, output halted);
endinterface

// File: rtl/cdec8_ctrl_dec.sv
// Combinational decoder of the CDEC8 sequencer.
//   i_st      : current state
//   i_I       : instruction register
//   i_SZCy    : {S,Z,Cy} flags (only looked at in S_O2 for Jcc)
//   i_run     : run enable (only looked at on instruction boundaries)
//   o_ctrl    : control word for the current state (Moore: st and I only)
//   o_next_st : next state
module cdec8_ctrl_dec
  import cdec8_ctrl_pkg::*;
(
  input  st_e        i_st,
  input  logic [7:0] i_I,
  input  logic [2:0] i_SZCy,
  input  logic       i_run,
  output ctrl_t      o_ctrl,
  output st_e        o_next_st
);

  logic [3:0] w_op;
  logic [1:0] w_r;
  logic [1:0] w_rd;
  st_e        w_bnd;
  ctrl_t      w_ctrl;
  st_e        w_next;

  assign w_op  = i_I[7:4];
  assign w_r   = i_I[1:0];
  assign w_rd  = i_I[3:2];
  assign w_bnd = i_run ? S_F0 : S_IDLE;

  always_comb begin
    w_ctrl = CTRL_IDLE;
    w_next = i_st;
    case (i_st)
      S_IDLE: w_next = w_bnd;
      S_F0, S_O0: begin
        w_ctrl.xsrc = XSRC_PC;
        w_ctrl.xdst = XDST_MAR;
        if (i_st == S_F0) w_next = S_F1;
        else              w_next = S_O1;
      end
      S_F1, S_O1: begin
        w_ctrl.mm    = MM_RD;
        w_ctrl.xsrc  = XSRC_PC;
        w_ctrl.aluop = ALU_INC;
        w_ctrl.rwr   = 1'b1;
        if (i_st == S_F1) w_next = S_F2;
        else              w_next = S_O2;
      end
      S_F2: begin
        w_ctrl.xsrc = XSRC_R;
        w_ctrl.xdst = XDST_PC;
        w_next      = S_F3;
      end
      S_O2: begin
        w_ctrl.xsrc = XSRC_R;
        w_ctrl.xdst = XDST_PC;
        // A Jcc that is not taken ends here; the operand was only skipped.
        if (w_op == OP_JCC && !jcc_taken(w_r, i_SZCy)) w_next = w_bnd;
        else                                           w_next = S_E0;
      end
      S_F3: begin
        w_ctrl.xsrc = XSRC_RDR;
        w_ctrl.xdst = XDST_I;
        case (w_op)
          OP_NOP, OP_UND:                         w_next = w_bnd;
          OP_HLT:                                 w_next = S_HALT;
          OP_LDI, OP_LDM, OP_ST, OP_JMP, OP_JCC:  w_next = S_O0;
          default:                                w_next = S_E0;
        endcase
      end
      S_E0: begin
        w_next = w_bnd;
        case (w_op)
          OP_LDI: begin
            w_ctrl.xsrc = XSRC_RDR;
            w_ctrl.xdst = reg_dst(w_r);
          end
          OP_LDM, OP_ST: begin
            w_ctrl.xsrc = XSRC_RDR;
            w_ctrl.xdst = XDST_MAR;
            w_next      = S_E1;
          end
          OP_MOV: begin
            w_ctrl.xsrc = reg_src(w_r);
            w_ctrl.xdst = reg_dst(w_rd);
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            w_ctrl.xsrc = reg_src(w_r);
            w_ctrl.xdst = XDST_T;
            w_next      = S_E1;
          end
          OP_INC: begin
            w_ctrl.xsrc = reg_src(w_r);
            if (i_I[2]) w_ctrl.aluop = ALU_DEC;
            else        w_ctrl.aluop = ALU_INC;
            w_ctrl.rwr  = 1'b1;
            w_ctrl.fwr  = 1'b1;
            w_next      = S_E1;
          end
          OP_JMP, OP_JCC: begin
            w_ctrl.xsrc = XSRC_RDR;
            w_ctrl.xdst = XDST_PC;
          end
          OP_IN: begin
            w_ctrl.xsrc = XSRC_IPORT;
            w_ctrl.xdst = reg_dst(w_r);
          end
          OP_OUT: begin
            w_ctrl.xsrc = reg_src(w_r);
            w_ctrl.xdst = XDST_OPORT;
          end
          default: ;
        endcase
      end
      S_E1: begin
        w_next = w_bnd;
        case (w_op)
          OP_LDM: begin
            w_ctrl.mm = MM_RD;
            w_next    = S_E2;
          end
          OP_ST: begin
            // ST carries its source register in the I[3:2] slot.
            w_ctrl.xsrc = reg_src(w_rd);
            w_ctrl.xdst = XDST_WDR;
            w_next      = S_E2;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            w_ctrl.xsrc  = XSRC_A;
            w_ctrl.aluop = alu_of(w_op);
            w_ctrl.rwr   = 1'b1;
            w_ctrl.fwr   = 1'b1;
            w_next       = S_E2;
          end
          OP_INC: begin
            w_ctrl.xsrc = XSRC_R;
            w_ctrl.xdst = reg_dst(w_r);
          end
          default: ;
        endcase
      end
      S_E2: begin
        w_next = w_bnd;
        case (w_op)
          OP_LDM: begin
            w_ctrl.xsrc = XSRC_RDR;
            w_ctrl.xdst = reg_dst(w_r);
          end
          OP_ST: w_ctrl.mm = MM_WR;
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            w_ctrl.xsrc = XSRC_R;
            w_ctrl.xdst = XDST_A;
          end
          default: ;
        endcase
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  assign o_ctrl    = w_ctrl;
  assign o_next_st = w_next;

endmodule

// File: rtl/cdec8_ctrl.sv
// CDEC8 control unit: Moore fetch/execute sequencer driving the datapath
// control word, one state per clock.
//   clock   : system clock, state changes on posedge
//   reset_N : asynchronous active-low reset (to S_IDLE)
//   bus     : slave side of cdec8_ctrl_if (run, I, SZCy in; ctrl, state,
//             halted out)
module cdec8_ctrl
  import cdec8_ctrl_pkg::*;
(
  input  logic          clock,
  input  logic          reset_N,
  cdec8_ctrl_if.slave   bus
);

  st_e   r_st;
  st_e   w_next_st;
  ctrl_t w_ctrl;

  cdec8_ctrl_dec u_dec (
    .i_st      (r_st),
    .i_I       (bus.I),
    .i_SZCy    (bus.SZCy),
    .i_run     (bus.run),
    .o_ctrl    (w_ctrl),
    .o_next_st (w_next_st)
  );

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) r_st <= S_IDLE;
    else          r_st <= w_next_st;
  end

  assign bus.ctrl   = w_ctrl;
  assign bus.state  = {4'h0, r_st};
  assign bus.halted = (r_st == S_HALT);

endmodule

// File: tb/tb_cdec8_ctrl.sv
module tb_cdec8_ctrl;
  import cdec8_ctrl_pkg::*;

  localparam logic [1:0] M_ID = 2'b00;
  localparam logic [1:0] M_RD = 2'b10;
  localparam logic [1:0] M_WR = 2'b01;

  localparam logic [3:0] XS_PC = 4'h0, XS_A = 4'h1, XS_B = 4'h2, XS_C = 4'h3,
                         XS_R = 4'h4, XS_RDR = 4'h5, XS_FF = 4'h7, XS_IPORT = 4'h8;
  localparam logic [3:0] XD_PC = 4'h0, XD_A = 4'h1, XD_B = 4'h2, XD_C = 4'h3,
                         XD_MAR = 4'h4, XD_WDR = 4'h5, XD_T = 4'h6, XD_I = 4'h7,
                         XD_OPORT = 4'h8, XD_NONE = 4'hF;

  function automatic logic [16:0] mk(input logic [1:0] mm, input logic fwr,
                                     input logic rwr, input logic [3:0] xd,
                                     input logic [4:0] alu, input logic [3:0] xs);
    return {mm, fwr, rwr, xd, alu, xs};
  endfunction

  localparam logic [16:0] W_IDLE = mk(M_ID, 1'b0, 1'b0, XD_NONE, ALU_THRU, XS_FF);
  localparam logic [16:0] W_F0   = mk(M_ID, 1'b0, 1'b0, XD_MAR,  ALU_THRU, XS_PC);
  localparam logic [16:0] W_F1   = mk(M_RD, 1'b0, 1'b1, XD_NONE, ALU_INC,  XS_PC);
  localparam logic [16:0] W_F2   = mk(M_ID, 1'b0, 1'b0, XD_PC,   ALU_THRU, XS_R);
  localparam logic [16:0] W_F3   = mk(M_ID, 1'b0, 1'b0, XD_I,    ALU_THRU, XS_RDR);

  logic clock;
  logic reset_N;
  cdec8_ctrl_if bus ();

  cdec8_ctrl dut (
    .clock   (clock),
    .reset_N (reset_N),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One expected cycle; run/i/f are the inputs driven right after it is checked.
  typedef struct {
    st_e         st;
    logic [16:0] ctrl;
    logic        halted;
    logic        run;
    logic [7:0]  i;
    logic [2:0]  f;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic        cur_run;
  logic [7:0]  cur_i;
  logic [2:0]  cur_f;

  function automatic void push(input st_e s, input logic [16:0] c);
    exp_t x;
    x.st = s; x.ctrl = c; x.halted = (s == S_HALT);
    x.run = cur_run; x.i = cur_i; x.f = cur_f;
    sb.push_back(x);
  endfunction

  function automatic void push_fetch();
    push(S_F0, W_F0); push(S_F1, W_F1); push(S_F2, W_F2); push(S_F3, W_F3);
  endfunction

  function automatic void push_oper();
    push(S_O0, W_F0); push(S_O1, W_F1); push(S_O2, W_F2);
  endfunction

  task automatic apply_reset();
    @(negedge clock);
    bus.run = 1'b0; bus.I = 8'h00; bus.SZCy = 3'b000;
    reset_N = 1'b0;
    @(negedge clock);
    reset_N = 1'b1;
  endtask

  task automatic start(input logic run, input logic [7:0] i, input logic [2:0] f);
    bus.run = run; bus.I = i; bus.SZCy = f;
    cur_run = run; cur_i = i; cur_f = f;
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if (bus.state !== 8'h00 || bus.ctrl !== W_IDLE || bus.halted !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: state=%h ctrl=%h halted=%b, expected state=00 ctrl=%h halted=0",
               bus.state, bus.ctrl, bus.halted, W_IDLE);
    end
    start(1'b0, 8'h00, 3'b000);
    push(S_IDLE, W_IDLE); push(S_IDLE, W_IDLE);
    cur_run = 1'b1;
    push(S_IDLE, W_IDLE);
    push(S_F0, W_F0);
    for (int k = 0; sb.size() != 0; k++) begin
      @(negedge clock);
      e = sb.pop_front();
      n_vec++;
      if (bus.state !== {4'h0, e.st} || bus.ctrl !== e.ctrl || bus.halted !== e.halted) begin
        n_err++;
        $display("FAIL reset_run step %0d: state=%h ctrl=%h halted=%b, expected state=%h ctrl=%h halted=%b",
                 k, bus.state, bus.ctrl, bus.halted, {4'h0, e.st}, e.ctrl, e.halted);
      end
      bus.run = e.run; bus.I = e.i; bus.SZCy = e.f;
    end
  endtask

  task automatic test_fetch_ld();
    apply_reset();
    start(1'b1, 8'h10, 3'b000);
    push_fetch(); push_oper();
    push(S_E0, mk(M_ID, 1'b0, 1'b0, XD_A, ALU_THRU, XS_RDR));
    push(S_F0, W_F0);
    for (int k = 0; sb.size() != 0; k++) begin
      @(negedge clock);
      e = sb.pop_front();
      n_vec++;
      if (bus.state !== {4'h0, e.st} || bus.ctrl !== e.ctrl || bus.halted !== e.halted) begin
        n_err++;
        $display("FAIL ld_imm step %0d: state=%h ctrl=%h halted=%b, expected state=%h ctrl=%h halted=%b",
                 k, bus.state, bus.ctrl, bus.halted, {4'h0, e.st}, e.ctrl, e.halted);
      end
      bus.run = e.run; bus.I = e.i; bus.SZCy = e.f;
    end
  endtask

  task automatic test_jcc();
    // JZ taken
    apply_reset();
    start(1'b1, 8'hB0, 3'b010);
    push_fetch(); push_oper();
    push(S_E0, mk(M_ID, 1'b0, 1'b0, XD_PC, ALU_THRU, XS_RDR));
    push(S_F0, W_F0);
    for (int k = 0; sb.size() != 0; k++) begin
      @(negedge clock);
      e = sb.pop_front();
      n_vec++;
      if (bus.state !== {4'h0, e.st} || bus.ctrl !== e.ctrl || bus.halted !== e.halted) begin
        n_err++;
        $display("FAIL jz_taken step %0d: state=%h ctrl=%h halted=%b, expected state=%h ctrl=%h halted=%b",
                 k, bus.state, bus.ctrl, bus.halted, {4'h0, e.st}, e.ctrl, e.halted);
      end
      bus.run = e.run; bus.I = e.i; bus.SZCy = e.f;
    end
    // JZ not taken: O2 goes straight to F0, no RDR->PC
    apply_reset();
    start(1'b1, 8'hB0, 3'b000);
    push_fetch(); push_oper();
    push(S_F0, W_F0); push(S_F1, W_F1);
    for (int k = 0; sb.size() != 0; k++) begin
      @(negedge clock);
      e = sb.pop_front();
      n_vec++;
      if (bus.state !== {4'h0, e.st} || bus.ctrl !== e.ctrl || bus.halted !== e.halted) begin
        n_err++;
        $display("FAIL jz_skip step %0d: state=%h ctrl=%h halted=%b, expected state=%h ctrl=%h halted=%b",
                 k, bus.state, bus.ctrl, bus.halted, {4'h0, e.st}, e.ctrl, e.halted);
      end
      bus.run = e.run; bus.I = e.i; bus.SZCy = e.f;
    end
  endtask

  task automatic test_alu();
    apply_reset();
    start(1'b1, 8'h52, 3'b000);
    push_fetch();
    push(S_E0, mk(M_ID, 1'b0, 1'b0, XD_T,    ALU_THRU, XS_C));
    push(S_E1, mk(M_ID, 1'b1, 1'b1, XD_NONE, ALU_ADD,  XS_A));
    push(S_E2, mk(M_ID, 1'b0, 1'b0, XD_A,    ALU_THRU, XS_R));
    cur_i = 8'h61;
    push_fetch();
    push(S_E0, mk(M_ID, 1'b0, 1'b0, XD_T,    ALU_THRU, XS_B));
    push(S_E1, mk(M_ID, 1'b1, 1'b1, XD_NONE, ALU_SUB,  XS_A));
    push(S_E2, mk(M_ID, 1'b0, 1'b0, XD_A,    ALU_THRU, XS_R));
    cur_i = 8'h73;
    push_fetch();
    push(S_E0, mk(M_ID, 1'b0, 1'b0, XD_T,    ALU_THRU, XS_FF));
    push(S_E1, mk(M_ID, 1'b1, 1'b1, XD_NONE, ALU_AND,  XS_A));
    push(S_E2, mk(M_ID, 1'b0, 1'b0, XD_A,    ALU_THRU, XS_R));
    cur_i = 8'h80;
    push_fetch();
    push(S_E0, mk(M_ID, 1'b0, 1'b0, XD_T,    ALU_THRU, XS_A));
    push(S_E1, mk(M_ID, 1'b1, 1'b1, XD_NONE, ALU_OR,   XS_A));
    push(S_E2, mk(M_ID, 1'b0, 1'b0, XD_A,    ALU_THRU, XS_R));
    push(S_F0, W_F0);
    for (int k = 0; sb.size() != 0; k++) begin
      @(negedge clock);
      e = sb.pop_front();
      n_vec++;
      if (bus.state !== {4'h0, e.st} || bus.ctrl !== e.ctrl || bus.halted !== e.halted) begin
        n_err++;
        $display("FAIL alu_ops step %0d: state=%h ctrl=%h halted=%b, expected state=%h ctrl=%h halted=%b",
                 k, bus.state, bus.ctrl, bus.halted, {4'h0, e.st}, e.ctrl, e.halted);
      end
      bus.run = e.run; bus.I = e.i; bus.SZCy = e.f;
    end
  endtask

  task automatic test_store_load();
    apply_reset();
    start(1'b1, 8'h3B, 3'b000);
    push_fetch(); push_oper();
    push(S_E0, mk(M_ID, 1'b0, 1'b0, XD_MAR,  ALU_THRU, XS_RDR));
    cur_run = 1'b0;  // run drops during E1; instruction still completes
    push(S_E1, mk(M_ID, 1'b0, 1'b0, XD_WDR,  ALU_THRU, XS_C));
    push(S_E2, mk(M_WR, 1'b0, 1'b0, XD_NONE, ALU_THRU, XS_FF));
    push(S_IDLE, W_IDLE);
    cur_run = 1'b1; cur_i = 8'h22;
    push(S_IDLE, W_IDLE);
    push_fetch(); push_oper();
    push(S_E0, mk(M_ID, 1'b0, 1'b0, XD_MAR,  ALU_THRU, XS_RDR));
    push(S_E1, mk(M_RD, 1'b0, 1'b0, XD_NONE, ALU_THRU, XS_FF));
    cur_run = 1'b0;
    push(S_E2, mk(M_ID, 1'b0, 1'b0, XD_C,    ALU_THRU, XS_RDR));
    push(S_IDLE, W_IDLE);
    for (int k = 0; sb.size() != 0; k++) begin
      @(negedge clock);
      e = sb.pop_front();
      n_vec++;
      if (bus.state !== {4'h0, e.st} || bus.ctrl !== e.ctrl || bus.halted !== e.halted) begin
        n_err++;
        $display("FAIL st_ld_mem step %0d: state=%h ctrl=%h halted=%b, expected state=%h ctrl=%h halted=%b",
                 k, bus.state, bus.ctrl, bus.halted, {4'h0, e.st}, e.ctrl, e.halted);
      end
      bus.run = e.run; bus.I = e.i; bus.SZCy = e.f;
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    start(1'b1, 8'h46, 3'b000);          // MOV B,C
    push_fetch();
    push(S_E0, mk(M_ID, 1'b0, 1'b0, XD_B, ALU_THRU, XS_C));
    cur_i = 8'h95;                       // DEC B
    push_fetch();
    push(S_E0, mk(M_ID, 1'b1, 1'b1, XD_NONE, ALU_DEC, XS_B));
    push(S_E1, mk(M_ID, 1'b0, 1'b0, XD_B,    ALU_THRU, XS_R));
    cur_i = 8'hC3;                       // IN special -> discarded
    push_fetch();
    push(S_E0, mk(M_ID, 1'b0, 1'b0, XD_NONE, ALU_THRU, XS_IPORT));
    cur_i = 8'hD1;                       // OUT B
    push_fetch();
    push(S_E0, mk(M_ID, 1'b0, 1'b0, XD_OPORT, ALU_THRU, XS_B));
    cur_i = 8'h00;                       // NOP
    push_fetch();
    cur_i = 8'hE0;                       // undefined -> NOP
    push_fetch();
    cur_i = 8'hB1; cur_f = 3'b110;       // JC, Cy=0 -> skip
    push_fetch(); push_oper();
    cur_i = 8'hB3; cur_f = 3'b100;       // JNZ, Z=0 -> taken
    push_fetch(); push_oper();
    push(S_E0, mk(M_ID, 1'b0, 1'b0, XD_PC, ALU_THRU, XS_RDR));
    cur_i = 8'h90;                       // INC A
    push_fetch();
    push(S_E0, mk(M_ID, 1'b1, 1'b1, XD_NONE, ALU_INC, XS_A));
    cur_run = 1'b0;
    push(S_E1, mk(M_ID, 1'b0, 1'b0, XD_A, ALU_THRU, XS_R));
    push(S_IDLE, W_IDLE);
    push(S_IDLE, W_IDLE);
    for (int k = 0; sb.size() != 0; k++) begin
      @(negedge clock);
      e = sb.pop_front();
      n_vec++;
      if (bus.state !== {4'h0, e.st} || bus.ctrl !== e.ctrl || bus.halted !== e.halted) begin
        n_err++;
        $display("FAIL back_to_back step %0d: state=%h ctrl=%h halted=%b, expected state=%h ctrl=%h halted=%b",
                 k, bus.state, bus.ctrl, bus.halted, {4'h0, e.st}, e.ctrl, e.halted);
      end
      bus.run = e.run; bus.I = e.i; bus.SZCy = e.f;
    end
  endtask

  task automatic test_halt_reset();
    apply_reset();
    start(1'b1, 8'hF0, 3'b000);
    push_fetch();
    for (int h = 0; h < 20; h++) push(S_HALT, W_IDLE);
    for (int k = 0; sb.size() != 0; k++) begin
      @(negedge clock);
      e = sb.pop_front();
      n_vec++;
      if (bus.state !== {4'h0, e.st} || bus.ctrl !== e.ctrl || bus.halted !== e.halted) begin
        n_err++;
        $display("FAIL halt step %0d: state=%h ctrl=%h halted=%b, expected state=%h ctrl=%h halted=%b",
                 k, bus.state, bus.ctrl, bus.halted, {4'h0, e.st}, e.ctrl, e.halted);
      end
      bus.run = e.run; bus.I = e.i; bus.SZCy = e.f;
    end
    // Async reset in the middle of ADD A,C (E1)
    apply_reset();
    start(1'b1, 8'h52, 3'b000);
    push_fetch();
    push(S_E0, mk(M_ID, 1'b0, 1'b0, XD_T,    ALU_THRU, XS_C));
    push(S_E1, mk(M_ID, 1'b1, 1'b1, XD_NONE, ALU_ADD,  XS_A));
    for (int k = 0; sb.size() != 0; k++) begin
      @(negedge clock);
      e = sb.pop_front();
      n_vec++;
      if (bus.state !== {4'h0, e.st} || bus.ctrl !== e.ctrl || bus.halted !== e.halted) begin
        n_err++;
        $display("FAIL pre_reset step %0d: state=%h ctrl=%h halted=%b, expected state=%h ctrl=%h halted=%b",
                 k, bus.state, bus.ctrl, bus.halted, {4'h0, e.st}, e.ctrl, e.halted);
      end
      bus.run = e.run; bus.I = e.i; bus.SZCy = e.f;
    end
    #2 reset_N = 1'b0;
    #1;
    n_vec++;
    if (bus.state !== 8'h00 || bus.ctrl !== W_IDLE || bus.halted !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: state=%h ctrl=%h halted=%b, expected state=00 ctrl=%h halted=0",
               bus.state, bus.ctrl, bus.halted, W_IDLE);
    end
    @(negedge clock);
    start(1'b0, 8'h52, 3'b000);
    reset_N = 1'b1;
    push(S_IDLE, W_IDLE); push(S_IDLE, W_IDLE);
    for (int k = 0; sb.size() != 0; k++) begin
      @(negedge clock);
      e = sb.pop_front();
      n_vec++;
      if (bus.state !== {4'h0, e.st} || bus.ctrl !== e.ctrl || bus.halted !== e.halted) begin
        n_err++;
        $display("FAIL post_reset step %0d: state=%h ctrl=%h halted=%b, expected state=%h ctrl=%h halted=%b",
                 k, bus.state, bus.ctrl, bus.halted, {4'h0, e.st}, e.ctrl, e.halted);
      end
      bus.run = e.run; bus.I = e.i; bus.SZCy = e.f;
    end
  endtask

  initial begin
    reset_N  = 1'b0;
    bus.run  = 1'b0;
    bus.I    = 8'h00;
    bus.SZCy = 3'b000;
    cur_run  = 1'b0;
    cur_i    = 8'h00;
    cur_f    = 3'b000;
    test_reset();
    test_fetch_ld();
    test_jcc();
    test_alu();
    test_store_load();
    test_back_to_back();
    test_halt_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion before it");
    $fatal(1);
  end

endmodule
